rob: RTL and testbench

//  In-order reorder buffer; the writer that drives the architectural register file's write port.

---
 rtl/rob_pkg.sv | 16 +
 rtl/rob.sv | 125 ++++++++++++
 tb/tb_rob.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/rob_pkg.sv
// Shared widths and types for the reorder buffer and the register-file
// write port it drives.
package rob_pkg;

  // Architectural register file geometry.
  localparam int RF_SIZE_LOG = 5;
  localparam int REG_LEN     = 32;

  // Default reorder-buffer geometry.
  localparam int ROB_SIZE     = 4;
  localparam int ROB_SIZE_LOG = 2;

  typedef logic [RF_SIZE_LOG-1:0] rf_addr_t;
  typedef logic [REG_LEN-1:0]     reg_data_t;

endpackage : rob_pkg

// File: rtl/rob.sv
// In-order reorder buffer. Dispatch allocates at the tail, execute completes
// entries out of order, and the head retires in order onto the register-file
// write port (rf_wen/rf_rd/rf_rd_data).
// Optional feature: define ROB_SQUASH_EN to add a squash input that flushes
// every entry and resets the pointers.
module rob
  import rob_pkg::*;
#(
  parameter int ROB_SIZE     = 4,
  parameter int ROB_SIZE_LOG = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    alloc_valid,
  output logic                    alloc_ready,
  input  logic                    alloc_wen,
  input  rf_addr_t                alloc_rd,
  output logic [ROB_SIZE_LOG-1:0] alloc_idx,
  input  logic                    wb_valid,
  input  logic [ROB_SIZE_LOG-1:0] wb_idx,
  input  reg_data_t               wb_data,
`ifdef ROB_SQUASH_EN
  input  logic                    squash,
`endif
  output logic                    commit_valid,
  output logic                    rf_wen,
  output rf_addr_t                rf_rd,
  output reg_data_t               rf_rd_data,
  output logic                    empty
);

  localparam logic [ROB_SIZE_LOG:0] FULL_COUNT = ROB_SIZE[ROB_SIZE_LOG:0];

  // Per-field entry storage.
  logic [ROB_SIZE-1:0] valid_q;
  logic [ROB_SIZE-1:0] done_q;
  logic                wen_q  [ROB_SIZE];
  rf_addr_t            rd_q   [ROB_SIZE];
  reg_data_t           data_q [ROB_SIZE];

  logic [ROB_SIZE_LOG-1:0] head_q;
  logic [ROB_SIZE_LOG-1:0] tail_q;
  logic [ROB_SIZE_LOG:0]   count_q;

  logic kill;
  logic alloc_fire;
  logic wb_fire;
  logic commit_fire;

`ifdef ROB_SQUASH_EN
  assign kill = squash;
`else
  assign kill = 1'b0;
`endif

  // Handshake and retire decisions, all from pre-edge state.
  always_comb begin
    alloc_ready = (count_q < FULL_COUNT);
    empty       = (count_q == '0);
    alloc_idx   = tail_q;
    alloc_fire  = alloc_valid & alloc_ready & ~kill;
    // The allocated slot is never valid pre-edge, so the explicit tail term
    // only documents that allocation wins over a same-cycle writeback.
    wb_fire     = wb_valid & valid_q[wb_idx] & ~kill
                  & ~(alloc_fire & (wb_idx == tail_q));
    commit_fire = valid_q[head_q] & done_q[head_q] & ~kill;
  end

  // Register-file write port driven straight from the head entry.
  always_comb begin
    commit_valid = commit_fire;
    rf_wen       = commit_fire & wen_q[head_q];
    rf_rd        = rd_q[head_q];
    rf_rd_data   = data_q[head_q];
  end

  // Entry status bits, pointers and occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      done_q  <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else if (kill) begin
      valid_q <= '0;
      done_q  <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (wb_fire) begin
        done_q[wb_idx] <= 1'b1;
      end
      // Retiring clears done after any same-cycle writeback to the head.
      if (commit_fire) begin
        valid_q[head_q] <= 1'b0;
        done_q[head_q]  <= 1'b0;
        head_q          <= head_q + 1'b1;
      end
      if (alloc_fire) begin
        valid_q[tail_q] <= 1'b1;
        done_q[tail_q]  <= 1'b0;
        tail_q          <= tail_q + 1'b1;
      end
      case ({alloc_fire, commit_fire})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Entry payload; meaningful only while the matching valid bit is set.
  always_ff @(posedge clk) begin
    if (alloc_fire) begin
      wen_q[tail_q] <= alloc_wen;
      rd_q[tail_q]  <= alloc_rd;
    end
    if (wb_fire) begin
      data_q[wb_idx] <= wb_data;
    end
  end

endmodule : rob

// File: tb/tb_rob.sv
// Self-checking bench for rob: directed scenarios with literal expectations
// plus randomized traffic checked every cycle against a queue-based model.
module tb_rob;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        alloc_valid = 1'b0;
  logic        alloc_ready;
  logic        alloc_wen = 1'b0;
  logic [4:0]  alloc_rd = '0;
  logic [1:0]  alloc_idx;
  logic        wb_valid = 1'b0;
  logic [1:0]  wb_idx = '0;
  logic [31:0] wb_data = '0;
  logic        squash = 1'b0;
  logic        commit_valid;
  logic        rf_wen;
  logic [4:0]  rf_rd;
  logic [31:0] rf_rd_data;
  logic        empty;

  int n_vec = 0;
  int n_err = 0;

  rob #(.ROB_SIZE(4), .ROB_SIZE_LOG(2)) dut (
    .clk          (clk),
    .rst          (rst),
    .alloc_valid  (alloc_valid),
    .alloc_ready  (alloc_ready),
    .alloc_wen    (alloc_wen),
    .alloc_rd     (alloc_rd),
    .alloc_idx    (alloc_idx),
    .wb_valid     (wb_valid),
    .wb_idx       (wb_idx),
    .wb_data      (wb_data),
`ifdef ROB_SQUASH_EN
    .squash       (squash),
`endif
    .commit_valid (commit_valid),
    .rf_wen       (rf_wen),
    .rf_rd        (rf_rd),
    .rf_rd_data   (rf_rd_data),
    .empty        (empty)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: program-order queue of in-flight instructions.
  typedef struct {
    bit        wen;
    bit [4:0]  rd;
    bit        done;
    bit [31:0] data;
  } ent_t;

  ent_t q[$];
  int   m_head = 0;
  bit   cmp_en = 1'b0;

  function automatic int m_tail();
    return (m_head + q.size()) % 4;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q.delete();
      m_head = 0;
    end else if (squash) begin
      q.delete();
      m_head = 0;
    end else begin
      int  pos;
      bit  can_alloc;
      bit  retire;
      ent_t e;
      can_alloc = (q.size() < 4);
      retire    = (q.size() > 0) && q[0].done;
      pos = (int'(wb_idx) - m_head + 4) % 4;
      if (wb_valid && pos < q.size()) begin
        q[pos].done = 1'b1;
        q[pos].data = wb_data;
      end
      if (retire) begin
        void'(q.pop_front());
        m_head = (m_head + 1) % 4;
      end
      if (alloc_valid && can_alloc) begin
        e.wen = alloc_wen; e.rd = alloc_rd; e.done = 1'b0; e.data = '0;
        q.push_back(e);
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (cmp_en) begin
      bit ecv;
      ecv = (q.size() > 0) && q[0].done && !squash;
      chk("alloc_ready", 32'(alloc_ready), 32'(q.size() < 4));
      chk("empty", 32'(empty), 32'(q.size() == 0));
      chk("alloc_idx", 32'(alloc_idx), 32'(m_tail()));
      chk("commit_valid", 32'(commit_valid), 32'(ecv));
      chk("rf_wen", 32'(rf_wen), 32'(ecv && q[0].wen));
      if (ecv && q[0].wen) begin
        chk("rf_rd", 32'(rf_rd), 32'(q[0].rd));
        chk("rf_rd_data", rf_rd_data, q[0].data);
      end
    end
  end

  task automatic drive(input bit av, input bit wen, input int rd,
                       input bit wv, input int widx, input logic [31:0] wd);
    alloc_valid = av;
    alloc_wen   = wen;
    alloc_rd    = 5'(rd);
    wb_valid    = wv;
    wb_idx      = 2'(widx);
    wb_data     = wd;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 0, 1'b0, 0, '0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [1:0] wrap_exp [6] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

  initial begin
    int idx;
    #1 rst = 1'b1;
    #11 rst = 1'b0;           // released mid-cycle at t=12
    cmp_en = 1'b1;
    chk("reset_empty", 32'(empty), 32'd1);
    chk("reset_ready", 32'(alloc_ready), 32'd1);
    chk("reset_commit", 32'(commit_valid), 32'd0);
    chk("reset_rf_wen", 32'(rf_wen), 32'd0);

    // In-order retire with out-of-order completion.
    drive(1, 1, 1, 0, 0, '0); tick();
    chk("inord_idx1", 32'(alloc_idx), 32'd1);
    drive(1, 1, 2, 0, 0, '0); tick();
    drive(0, 0, 0, 1, 1, 32'hBB); tick();
    chk("inord_wait", 32'(commit_valid), 32'd0);
    drive(0, 0, 0, 1, 0, 32'hAA); tick();
    chk("inord_c1_wen", 32'(rf_wen), 32'd1);
    chk("inord_c1_rd", 32'(rf_rd), 32'd1);
    chk("inord_c1_data", rf_rd_data, 32'hAA);
    idle(); tick();
    chk("inord_c2_rd", 32'(rf_rd), 32'd2);
    chk("inord_c2_data", rf_rd_data, 32'hBB);
    tick();
    chk("inord_empty", 32'(empty), 32'd1);

    // Full: head/tail are both 2 here.
    for (int k = 0; k < 4; k++) begin
      drive(1, 1, 3 + k, 0, 0, '0); tick();
    end
    chk("full_ready", 32'(alloc_ready), 32'd0);
    drive(1, 1, 9, 0, 0, '0); tick();
    chk("full_refused_idx", 32'(alloc_idx), 32'd2);
    drive(1, 1, 9, 1, 2, 32'h11); tick();
    chk("full_commit", 32'(commit_valid), 32'd1);
    chk("full_commit_ready", 32'(alloc_ready), 32'd0);
    drive(1, 1, 9, 0, 0, '0); tick();
    chk("full_after_commit_ready", 32'(alloc_ready), 32'd1);
    chk("full_after_commit_idx", 32'(alloc_idx), 32'd2);
    tick();
    chk("full_late_alloc_idx", 32'(alloc_idx), 32'd3);
    chk("full_late_alloc_ready", 32'(alloc_ready), 32'd0);

    // Reset mid-run with three valid entries.
    idle();
    for (int k = 0; k < 4; k++) begin
      drive(0, 0, 0, 1, k, 32'h200 + k); tick();
    end
    idle();
    for (int k = 0; k < 6; k++) tick();
    for (int k = 0; k < 3; k++) begin
      drive(1, 1, 10 + k, 0, 0, '0); tick();
    end
    idle();
    #2 rst = 1'b1;
    #1;
    chk("rst_mid_empty", 32'(empty), 32'd1);
    chk("rst_mid_ready", 32'(alloc_ready), 32'd1);
    chk("rst_mid_commit", 32'(commit_valid), 32'd0);
    chk("rst_mid_rf_wen", 32'(rf_wen), 32'd0);
    #1 rst = 1'b0;
    tick();

    // Wrap-around of the index.
    for (int k = 0; k < 6; k++) begin
      chk("wrap_idx", 32'(alloc_idx), 32'(wrap_exp[k]));
      idx = int'(alloc_idx);
      drive(1, 1, k + 1, 0, 0, '0); tick();
      drive(0, 0, 0, 1, idx, 32'h100 + k); tick();
      idle();
      chk("wrap_rd", 32'(rf_rd), 32'(k + 1));
      chk("wrap_data", rf_rd_data, 32'h100 + k);
      tick();
    end

    // No-write entry retires without a register-file write.
    idx = int'(alloc_idx);
    drive(1, 0, 7, 0, 0, '0); tick();
    drive(0, 0, 0, 1, idx, 32'h55); tick();
    idle();
    chk("nowr_commit", 32'(commit_valid), 32'd1);
    chk("nowr_rf_wen", 32'(rf_wen), 32'd0);
    tick();

`ifdef ROB_SQUASH_EN
    rst = 1'b1; #1 rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      drive(1, 1, 20 + k, 0, 0, '0); tick();
    end
    drive(0, 0, 0, 1, 0, 32'h77); tick();
    idle();
    squash = 1'b1; #1;
    chk("sq_rf_wen", 32'(rf_wen), 32'd0);
    chk("sq_commit", 32'(commit_valid), 32'd0);
    tick();
    squash = 1'b0;
    chk("sq_empty", 32'(empty), 32'd1);
    chk("sq_idx", 32'(alloc_idx), 32'd0);
    drive(0, 0, 0, 1, 1, 32'h99); tick();
    idle();
    chk("sq_stale_wb", 32'(commit_valid), 32'd0);
    chk("sq_stale_empty", 32'(empty), 32'd1);
    tick();
`endif

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      drive($urandom_range(0, 9) < 6, $urandom_range(0, 3) != 0,
            int'($urandom_range(0, 31)), $urandom_range(0, 9) < 6,
            int'($urandom_range(0, 3)), $urandom);
`ifdef ROB_SQUASH_EN
      squash = ($urandom_range(0, 99) == 0);
`endif
      tick();
    end
    idle();
    squash = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_rob
